// File: rtl/hello_pkg.sv
// Shared constants and helpers for the hello counter family.
package hello_pkg;

  localparam int DEFAULT_WIDTH = 11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Callers cast the result back to their own counter width.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/hello_cnt_chan.sv
// One counter channel: count register, terminal-count pulse, sticky overflow
// and the boundary handling for wrap or saturate mode.
module hello_cnt_chan
  import hello_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LIMIT    = 2**WIDTH - 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  input  logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam bit               SAT = (SATURATE == MODE_SAT);

  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

  // Boundary compares against LIM explicitly so a LIMIT below 2**WIDTH-1 wraps exactly there.
  always_comb begin
    step         = en & tick;
    boundary     = 1'b0;
    step_val     = cnt;
    load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(LIMIT)));
    if (dir == DIR_UP) begin
      boundary = (cnt == LIM);
      step_val = boundary ? (SAT ? LIM : '0) : cnt + WIDTH'(1);
    end else begin
      boundary = (cnt == '0);
      step_val = boundary ? (SAT ? '0 : LIM) : cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (load) begin
        cnt <= load_clamped;
        tc  <= 1'b0;
      end else if (step) begin
        cnt <= step_val;
        tc  <= boundary;
      end else begin
        tc  <= 1'b0;
      end
      // A fresh boundary event beats a simultaneous clear.
      ovf <= (~load & step & boundary) | (ovf & ~clr_ovf);
    end
  end

`ifdef FORMAL
  logic past_valid = 1'b0;

  always_ff @(posedge clk) past_valid <= 1'b1;

  always_comb begin
    assert (cnt <= LIM);
    if (tc) assert (ovf);
  end

  always_ff @(posedge clk) begin
    if (past_valid) begin
      if ($past(rst)) assert (cnt == '0 && !tc && !ovf);
      if (!$past(rst) && !$past(en) && !$past(load)) assert (cnt == $past(cnt));
      if (!SAT && !$past(rst) && !$past(load) && $past(step) &&
          $past(dir) == DIR_UP && $past(cnt) == LIM)
        assert (cnt == '0);
    end
  end
`endif

endmodule

// File: rtl/hello_cnt_multi.sv
// NCH independent up/down counters sharing a single prescaler that
// generates the count tick.
module hello_cnt_multi
  import hello_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NCH      = 2,
  parameter int LIMIT    = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       dir,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic                 clr_ovf,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       ovf,
  output logic                 tick
);

  localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt == PLAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == PLAST) & ~rst;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    hello_cnt_chan #(
      .WIDTH   (WIDTH),
      .LIMIT   (LIMIT),
      .SATURATE(SATURATE)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .dir     (dir[i]),
      .load    (load[i]),
      .load_val(load_val[i*WIDTH +: WIDTH]),
      .clr_ovf (clr_ovf),
      .tick    (tick),
      .cnt     (cnt[i*WIDTH +: WIDTH]),
      .tc      (tc[i]),
      .ovf     (ovf[i])
    );
  end

endmodule

// File: tb/tb_hello_cnt_multi.sv
// Directed bench for hello_cnt_multi: wrap, saturate and prescaled instances
// with WIDTH=4, LIMIT=9, NCH=2.
module tb_hello_cnt_multi;

  logic clk;

  logic       w_rst, w_clr, w_tick;
  logic [1:0] w_en, w_dir, w_load, w_tc, w_ovf;
  logic [7:0] w_lv, w_cnt;

  logic       s_rst, s_clr, s_tick;
  logic [1:0] s_en, s_dir, s_load, s_tc, s_ovf;
  logic [7:0] s_lv, s_cnt;

  logic       p_rst, p_clr, p_tick;
  logic [1:0] p_en, p_dir, p_load, p_tc, p_ovf;
  logic [7:0] p_lv, p_cnt;

  int checks = 0;
  int passes = 0;

  hello_cnt_multi #(.WIDTH(4), .NCH(2), .LIMIT(9), .PRESCALE(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(w_rst), .en(w_en), .dir(w_dir), .load(w_load), .load_val(w_lv),
    .clr_ovf(w_clr), .cnt(w_cnt), .tc(w_tc), .ovf(w_ovf), .tick(w_tick));

  hello_cnt_multi #(.WIDTH(4), .NCH(2), .LIMIT(9), .PRESCALE(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .dir(s_dir), .load(s_load), .load_val(s_lv),
    .clr_ovf(s_clr), .cnt(s_cnt), .tc(s_tc), .ovf(s_ovf), .tick(s_tick));

  hello_cnt_multi #(.WIDTH(4), .NCH(2), .LIMIT(9), .PRESCALE(4), .SATURATE(0)) u_pre (
    .clk(clk), .rst(p_rst), .en(p_en), .dir(p_dir), .load(p_load), .load_val(p_lv),
    .clr_ovf(p_clr), .cnt(p_cnt), .tc(p_tc), .ovf(p_ovf), .tick(p_tick));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  initial begin
    int exp_cnt;

    w_rst = 1'b1; w_clr = 1'b0; w_en = '0; w_dir = '0; w_load = '0; w_lv = '0;
    s_rst = 1'b1; s_clr = 1'b0; s_en = '0; s_dir = '0; s_load = '0; s_lv = '0;
    p_rst = 1'b1; p_clr = 1'b0; p_en = '0; p_dir = '0; p_load = '0; p_lv = '0;

    applyStimulus(2);
    checkOutput("w_reset_cnt", 32'(w_cnt), 0);
    checkOutput("w_reset_tc", 32'(w_tc), 0);
    checkOutput("w_reset_ovf", 32'(w_ovf), 0);
    checkOutput("w_reset_tick", 32'(w_tick), 0);
    checkOutput("s_reset_cnt", 32'(s_cnt), 0);
    checkOutput("p_reset_cnt", 32'(p_cnt), 0);

    // Wrap mode: ch0 counts up 1..9,0,1,2 while ch1 stays idle.
    w_rst = 1'b0; w_en = 2'b01; w_dir = 2'b00;
    #1;
    checkOutput("w_tick_free", 32'(w_tick), 1);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1);
      exp_cnt = (k <= 9) ? k : k - 10;
      checkOutput($sformatf("w_up_cnt0_%0d", k), 32'(w_cnt[3:0]), 32'(exp_cnt));
      checkOutput($sformatf("w_up_tc0_%0d", k), 32'(w_tc[0]), (k == 10) ? 1 : 0);
      checkOutput($sformatf("w_up_ovf0_%0d", k), 32'(w_ovf[0]), (k >= 10) ? 1 : 0);
      checkOutput($sformatf("w_up_cnt1_%0d", k), 32'(w_cnt[7:4]), 0);
    end

    applyStimulus(7);
    checkOutput("w_at_limit", 32'(w_cnt[3:0]), 9);

    // Load beats the step that would otherwise wrap.
    w_load = 2'b01; w_lv = 8'h03;
    applyStimulus(1);
    checkOutput("w_simul_cnt0", 32'(w_cnt[3:0]), 3);
    checkOutput("w_simul_tc0", 32'(w_tc[0]), 0);
    checkOutput("w_simul_ovf0", 32'(w_ovf[0]), 1);
    w_load = 2'b00;

    applyStimulus(6);
    checkOutput("w_at_limit2", 32'(w_cnt[3:0]), 9);
    w_clr = 1'b1;
    applyStimulus(1);
    checkOutput("w_clrset_cnt0", 32'(w_cnt[3:0]), 0);
    checkOutput("w_clrset_tc0", 32'(w_tc[0]), 1);
    checkOutput("w_clrset_ovf0", 32'(w_ovf[0]), 1);
    w_clr = 1'b0;

    // ch1 underflows from 0 to LIMIT, then a clamped load keeps ovf1.
    w_en = 2'b11; w_dir = 2'b10;
    applyStimulus(1);
    checkOutput("w_down_cnt1", 32'(w_cnt[7:4]), 9);
    checkOutput("w_down_tc1", 32'(w_tc[1]), 1);
    checkOutput("w_down_ovf1", 32'(w_ovf[1]), 1);
    checkOutput("w_dirsplit_cnt0", 32'(w_cnt[3:0]), 1);
    w_en = 2'b01; w_dir = 2'b00; w_load = 2'b10; w_lv = 8'hF0;
    applyStimulus(1);
    checkOutput("w_clamp_cnt1", 32'(w_cnt[7:4]), 9);
    checkOutput("w_clamp_tc1", 32'(w_tc[1]), 0);
    checkOutput("w_clamp_ovf1", 32'(w_ovf[1]), 1);
    checkOutput("w_clamp_cnt0", 32'(w_cnt[3:0]), 2);
    w_load = 2'b00;

    applyStimulus(3);
    checkOutput("w_pre_rst_cnt0", 32'(w_cnt[3:0]), 5);
    checkOutput("w_pre_rst_ovf0", 32'(w_ovf[0]), 1);
    w_rst = 1'b1;
    #1;
    checkOutput("w_rst_tick", 32'(w_tick), 0);
    applyStimulus(1);
    checkOutput("w_rst_cnt", 32'(w_cnt), 0);
    checkOutput("w_rst_tc", 32'(w_tc), 0);
    checkOutput("w_rst_ovf", 32'(w_ovf), 0);
    w_rst = 1'b0; w_en = 2'b00;

    // Saturate mode: load 2, count down into 0 and keep trying.
    s_rst = 1'b0; s_load = 2'b01; s_lv = 8'h02;
    applyStimulus(1);
    checkOutput("s_load_cnt0", 32'(s_cnt[3:0]), 2);
    checkOutput("s_load_tc0", 32'(s_tc[0]), 0);
    s_load = 2'b00; s_en = 2'b01; s_dir = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("s_down_cnt0_%0d", k), 32'(s_cnt[3:0]), (k == 1) ? 1 : 0);
      checkOutput($sformatf("s_down_tc0_%0d", k), 32'(s_tc[0]), (k >= 3) ? 1 : 0);
      checkOutput($sformatf("s_down_ovf0_%0d", k), 32'(s_ovf[0]), (k >= 3) ? 1 : 0);
    end
    s_load = 2'b01; s_lv = 8'h09;
    applyStimulus(1);
    checkOutput("s_load9_cnt0", 32'(s_cnt[3:0]), 9);
    checkOutput("s_load9_tc0", 32'(s_tc[0]), 0);
    s_load = 2'b00; s_dir = 2'b00;
    applyStimulus(1);
    checkOutput("s_uptop_cnt0", 32'(s_cnt[3:0]), 9);
    checkOutput("s_uptop_tc0", 32'(s_tc[0]), 1);
    s_en = 2'b00;
    applyStimulus(1);
    checkOutput("s_hold_cnt0", 32'(s_cnt[3:0]), 9);
    checkOutput("s_hold_tc0", 32'(s_tc[0]), 0);
    checkOutput("s_hold_ovf0", 32'(s_ovf[0]), 1);

    // Prescale 4: tick on every 4th cycle, count advances at edges 4 and 8.
    p_rst = 1'b0; p_en = 2'b01; p_dir = 2'b00;
    #1;
    checkOutput("p_tick_0", 32'(p_tick), 0);
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("p_tick_%0d", c), 32'(p_tick), (c % 4 == 3) ? 1 : 0);
      checkOutput($sformatf("p_cnt0_%0d", c), 32'(p_cnt[3:0]), 32'(c / 4));
    end
    p_load = 2'b01; p_lv = 8'h07;
    applyStimulus(1);
    checkOutput("p_load_notick", 32'(p_cnt[3:0]), 7);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
